// File: rtl/execute_stage.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU,
// branch/jump resolution, PC target generation and an iterative shift-add
// multiplier that holds the E instruction while it runs.
module execute_stage #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ALUControlE,
    input  logic        ALUSrcE,
    input  logic        LUIInstrE,
    input  logic [2:0]  BranchE,
    input  logic [1:0]  JumpE,
    input  logic        MulE,
    input  logic [31:0] RD1E,
    input  logic [31:0] RD2E,
    input  logic [31:0] PCE,
    input  logic [31:0] ExtImmE,
    input  logic [31:0] PCPlus4E,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] ResultW,
    output logic [31:0] ALUResultE,
    output logic [31:0] WriteDataE,
    output logic [31:0] PCTargetE,
    output logic        PCSrcE,
    output logic        MulBusyE
);

    localparam int unsigned B = BITS_PER_CYCLE;
    localparam int unsigned N = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] CntLast = 6'(N - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} mulState_t;

    mulState_t   mulStateQ, mulStateD;
    logic [31:0] mcandQ, mcandD;
    logic [31:0] mplierQ, mplierD;
    logic [31:0] accQ, accD;
    logic [5:0]  cntQ, cntD;
    logic        mulBusy;

    logic [31:0] fwdA, fwdB, srcA, srcB;
    logic [31:0] aluResult, jalrSum, partProd;
    logic        isEq, isLt, isLtu, branchTaken, isJump;

    // Forwarding muxes; 00 and 11 both select the register file value.
    always_comb begin
        unique case (ForwardAE)
            2'b01:   fwdA = ResultW;
            2'b10:   fwdA = ALUResultM;
            default: fwdA = RD1E;
        endcase
        unique case (ForwardBE)
            2'b01:   fwdB = ResultW;
            2'b10:   fwdB = ALUResultM;
            default: fwdB = RD2E;
        endcase
        srcA       = fwdA;
        srcB       = ALUSrcE ? ExtImmE : fwdB;
        WriteDataE = fwdB;
    end

    // ALU.
    always_comb begin
        unique case (ALUControlE)
            3'b000:  aluResult = srcA + srcB;
            3'b001:  aluResult = srcA - srcB;
            3'b010:  aluResult = srcA & srcB;
            3'b011:  aluResult = srcA | srcB;
            3'b100:  aluResult = srcA ^ srcB;
            3'b101:  aluResult = {31'b0, $signed(srcA) < $signed(srcB)};
            3'b110:  aluResult = {31'b0, srcA < srcB};
            default: aluResult = srcA << srcB[4:0];
        endcase
    end

    // Branch compare always uses the forwarded registers, never the immediate.
    always_comb begin
        isEq  = (fwdA == fwdB);
        isLt  = ($signed(fwdA) < $signed(fwdB));
        isLtu = (fwdA < fwdB);
        unique case (BranchE)
            3'b001:  branchTaken = isEq;
            3'b010:  branchTaken = !isEq;
            3'b011:  branchTaken = isLt;
            3'b100:  branchTaken = !isLt;
            3'b101:  branchTaken = isLtu;
            3'b110:  branchTaken = !isLtu;
            default: branchTaken = 1'b0;
        endcase
        isJump    = (JumpE == 2'b01) || (JumpE == 2'b10);
        jalrSum   = srcA + ExtImmE;
        PCTargetE = (JumpE == 2'b10) ? {jalrSum[31:1], 1'b0} : PCE + ExtImmE;
        // A MUL never redirects, whatever the branch/jump fields hold.
        PCSrcE    = (isJump || branchTaken) && !MulE;
    end

    // Result select: LUI, then a finished product, then link address, then ALU.
    always_comb begin
        if (LUIInstrE)                ALUResultE = ExtImmE;
        else if (mulStateQ == StDone) ALUResultE = accQ;
        else if (isJump)              ALUResultE = PCPlus4E;
        else                          ALUResultE = aluResult;
    end

    // Partial product of the multiplicand and the low B multiplier bits.
    always_comb begin
        partProd = '0;
        for (int unsigned i = 0; i < B; i++) begin
            if (mplierQ[i]) partProd = partProd + (mcandQ << i);
        end
    end

    // Multiplier next state; busy rises combinationally on the start cycle.
    always_comb begin
        mulStateD = mulStateQ;
        mcandD    = mcandQ;
        mplierD   = mplierQ;
        accD      = accQ;
        cntD      = cntQ;
        mulBusy   = 1'b0;
        unique case (mulStateQ)
            StIdle: begin
                if (MulE) begin
                    mcandD    = srcA;
                    mplierD   = srcB;
                    accD      = '0;
                    cntD      = '0;
                    mulBusy   = 1'b1;
                    mulStateD = StBusy;
                end
            end
            StBusy: begin
                accD    = accQ + partProd;
                mcandD  = mcandQ << B;
                mplierD = mplierQ >> B;
                cntD    = cntQ + 6'd1;
                mulBusy = 1'b1;
                if (cntQ == CntLast) mulStateD = StDone;
            end
            StDone:  mulStateD = StIdle;
            default: mulStateD = StIdle;
        endcase
    end

    // Busy is masked while reset is held so a pending MulE cannot stall the pipe.
    assign MulBusyE = mulBusy && rst;

    // Multiplier state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mulStateQ <= StIdle;
            mcandQ    <= '0;
            mplierQ   <= '0;
            accQ      <= '0;
            cntQ      <= '0;
        end else begin
            mulStateQ <= mulStateD;
            mcandQ    <= mcandD;
            mplierQ   <= mplierD;
            accQ      <= accD;
            cntQ      <= cntD;
        end
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (E) stage of the 5-stage RV32I pipeline. It consumes the registered decode-to-execute bundle directly.
- Contains the operand forwarding muxes, the ALU, branch/jump resolution and PC target generation.
- Contains an iterative shift-add multiplier that holds the E instruction with a busy signal until the product is ready.
- Outputs feed the E-to-M pipeline register and the hazard unit.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration. Legal values: 1, 2, 4. N = 32/BITS_PER_CYCLE iterations.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- ALUControlE  in  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu, 111 sll
- ALUSrcE  in  1  1 = SrcB is ExtImmE
- LUIInstrE  in  1  1 = result is ExtImmE
- BranchE  in  3  000 none, 001 beq, 010 bne, 011 blt, 100 bge, 101 bltu, 110 bgeu, 111 none
- JumpE  in  2  00 none, 01 jal, 10 jalr, 11 none
- MulE  in  1  E instruction is MUL (low 32 bits of product)
- RD1E, RD2E, PCE, ExtImmE, PCPlus4E  in  32 each  E operands
- ForwardAE, ForwardBE  in  2 each  00 register value, 01 ResultW, 10 ALUResultM, 11 register value
- ALUResultM, ResultW  in  32 each  forwarding sources
- ALUResultE  out  32  result to M
- WriteDataE  out  32  forwarded rs2 (store data)
- PCTargetE  out  32  redirect target
- PCSrcE  out  1  redirect taken
- MulBusyE  out  1  hazard unit stalls F/D/E and bubbles M while high

Behaviour:
- FwdA = mux(ForwardAE). FwdB = mux(ForwardBE). SrcA = FwdA. SrcB = ALUSrcE ? ExtImmE : FwdB. WriteDataE = FwdB.
- ALU is combinational, with 32-bit wrap arithmetic. slt is signed, sltu is unsigned, sll uses SrcB[4:0].
- ALUResultE priority:
  - LUIInstrE → ExtImmE
  - else mul state DONE → product register
  - else ALU result
- Branch compare is always FwdA vs FwdB (never the immediate).
- Jumps:
  - Target for jalr = (SrcA + ExtImmE) & ~1.
  - Target otherwise = PCE + ExtImmE.
  - PCSrcE = (JumpE is 01 or 10) | branch condition true.
  - On jal/jalr, ALUResultE = PCPlus4E.
- PCSrcE is forced to 0 whenever MulE = 1.
- Multiplier FSM (sequential; all other logic is combinational):
  - IDLE:
    - If MulE = 1: capture multiplicand = SrcA and multiplier = SrcB into registers, clear accumulator and counter, assert MulBusyE (combinationally, same cycle), go to BUSY.
    - Else MulBusyE = 0.
  - BUSY:
    - Each cycle, add (multiplicand × multiplier[B-1:0]) to the accumulator, shift the multiplicand left by B, shift the multiplier right by B, and increment the counter. MulBusyE = 1.
    - After the Nth iteration, go to DONE.
  - DONE:
    - MulBusyE = 0 and ALUResultE = accumulator, so the instruction advances to M this cycle.
    - Next state is IDLE unconditionally, so back-to-back MULs restart in the following cycle.
- MUL latency: E occupancy is N+2 cycles (34 for B = 1, 18 for B = 2, 10 for B = 4).
- Operands are captured on the start cycle only; later changes to the forwarding sources while BUSY are ignored.
- Reset: asynchronous on rst low.
  - State returns to IDLE; accumulator, counter and operand registers clear to 0.
  - MulBusyE = 0 during and after reset.
  - Combinational outputs follow their inputs.
  - Reset during BUSY abandons the multiply; no result is produced.
- MulE deasserting while BUSY is illegal; the FSM completes anyway.

Test Plan:
- Forwarding: ALUControlE = 000, ForwardAE = 10, ALUResultM = 0x10, ForwardBE = 01, ResultW = 0x5 → ALUResultE = 0x15, WriteDataE = 0x5.
- Branch signed vs unsigned:
  - FwdA = 0xFFFFFFFF, FwdB = 1, BranchE = 011 (blt) → PCSrcE = 1.
  - Same operands, BranchE = 101 (bltu) → PCSrcE = 0.
  - Target = PCE + ExtImmE = 0x100 + 0x20 = 0x120.
- jalr: SrcA = 0x1003, ExtImmE = 0x4, JumpE = 10 → PCTargetE = 0x1006, PCSrcE = 1, ALUResultE = PCPlus4E.
- MUL, B = 1: SrcA = 0xFFFFFFFF (-1), SrcB = 7, MulE held high → MulBusyE high for 33 cycles, then DONE with ALUResultE = 0xFFFFFFF9 and MulBusyE = 0. Repeat with B = 4: busy for 9 cycles.
- Operand capture: start MUL with ResultW = 3 forwarded and SrcB = 5, then change ResultW to 9 on the next cycle → product = 15.
- Reset mid-multiply: drop rst at iteration 10 → MulBusyE = 0 immediately, state IDLE. A new MUL of 6 × 7 after release → 42 with full latency.
